// File: rtl/cov_mon_pkg.sv
// Shared types and arithmetic helpers for the multi-channel coverage stall monitor.
// Helpers work on 64-bit values and take the saturation ceiling as an argument so any width up to 64 fits.
package cov_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRED = 2'd1,
    DRAIN = 2'd2
  } mon_state_e;

  // The watchdog cause sits just above the per-channel cause bits.
  function automatic int wdog_bit(input int num_ch);
    return num_ch;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[63:0];
  endfunction

  function automatic logic [63:0] sat_mul(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [127:0] prod;
    prod = {64'd0, a} * {64'd0, b};
    if (prod > {64'd0, max_v}) return max_v;
    return prod[63:0];
  endfunction

endpackage

// File: rtl/cov_stall_channel.sv
// One coverage probe: snapshot, saturating stall counter and progress-scaled threshold compare.
// Counter clears one cycle after a probe change; clr reloads the snapshot regardless of en.
module cov_stall_channel
  import cov_mon_pkg::*;
#(
  parameter int COV_W       = 30,
  parameter int CNT_W       = 32,
  parameter int BASE_WAIT   = 1000,
  parameter int SCALE_SHIFT = 19
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [COV_W-1:0] cov_i,
  input  logic             mask_i,
  output logic             stall_i,
  output logic [CNT_W-1:0] cnt_i
);

  localparam logic [63:0] CNT_MAX = {{(64-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [COV_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr;

  // Deeper progress earns proportionally more patience before a stall is declared.
  always_comb begin
    thr = CNT_W'(sat_mul(64'(BASE_WAIT), 64'(cov_i >> SCALE_SHIFT) + 64'd1, CNT_MAX));
  end

  always_comb begin
    snap_d = snap_q;
    cnt_d  = cnt_q;
    if (clr) begin
      snap_d = cov_i;
      cnt_d  = '0;
    end else if (en) begin
      if (cov_i != snap_q) begin
        snap_d = cov_i;
        cnt_d  = '0;
      end else begin
        cnt_d = CNT_W'(sat_add(64'(cnt_q), 64'd1, CNT_MAX));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      snap_q <= '0;
      cnt_q  <= '0;
    end else begin
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_i = mask_i & (cnt_q >= thr);
  assign cnt_i   = cnt_q;

endmodule

// File: rtl/cov_stall_monitor.sv
// Multi-channel coverage stall monitor with global watchdog, sticky irq, ack handshake and hold-off.
// irq rises one cycle after a counter meets its threshold; done dominates ack and detection.
module cov_stall_monitor
  import cov_mon_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int COV_W       = 30,
  parameter int CNT_W       = 32,
  parameter int BASE_WAIT   = 1000,
  parameter int SCALE_SHIFT = 19,
  parameter int WDOG_W      = 32,
  parameter int WDOG_LIMIT  = 50000,
  parameter int HOLDOFF     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_CH*COV_W-1:0] cov,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic                    done,
  input  logic                    irq_ack,
  output logic                    irq,
  output logic [NUM_CH:0]         irq_cause,
  output logic [CNT_W-1:0]        stall_cnt_max
);

  localparam int          WB       = wdog_bit(NUM_CH);
  localparam int          HW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [63:0] WDOG_MAX = {{(64-WDOG_W){1'b0}}, {WDOG_W{1'b1}}};

  mon_state_e        state_q, state_d;
  logic              irq_q, irq_d;
  logic [NUM_CH:0]   cause_q, cause_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0]  max_q, max_d;

  logic [NUM_CH-1:0] stall;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              ack_ok;
  logic              clr;
  logic              wd_hit;

  // An ack only counts while an interrupt is outstanding and the monitor is running.
  assign ack_ok = en & (state_q == FIRED) & irq_ack;
  assign clr    = done | ack_ok;
  assign wd_hit = wdog_q >= WDOG_W'(WDOG_LIMIT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cov_stall_channel #(
      .COV_W       (COV_W),
      .CNT_W       (CNT_W),
      .BASE_WAIT   (BASE_WAIT),
      .SCALE_SHIFT (SCALE_SHIFT)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .clr     (clr),
      .cov_i   (cov[i*COV_W +: COV_W]),
      .mask_i  (ch_mask[i]),
      .stall_i (stall[i]),
      .cnt_i   (cnt[i])
    );
  end

  always_comb begin
    wdog_d = wdog_q;
    if (clr) begin
      wdog_d = '0;
    end else if (en) begin
      if (state_q == DRAIN) wdog_d = '0;
      else wdog_d = WDOG_W'(sat_add(64'(wdog_q), 64'd1, WDOG_MAX));
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    if (done) begin
      state_d = IDLE;
      irq_d   = 1'b0;
      cause_d = '0;
      hold_d  = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if ((|stall) || wd_hit) begin
            state_d                 = FIRED;
            irq_d                   = 1'b1;
            cause_d[WB]             = wd_hit;
            cause_d[NUM_CH-1:0]     = stall;
          end
        end
        FIRED: begin
          if (irq_ack) begin
            irq_d = 1'b0;
            if (HOLDOFF == 0) begin
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
              hold_d  = HW'(HOLDOFF - 1);
            end
          end
        end
        DRAIN: begin
          if (hold_q == '0) state_d = IDLE;
          else hold_d = hold_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    max_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt[i] > max_d) max_d = cnt[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      cause_q <= '0;
      hold_q  <= '0;
      wdog_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      wdog_q  <= wdog_d;
      max_q   <= max_d;
    end
  end

  assign irq           = irq_q;
  assign irq_cause     = cause_q;
  assign stall_cnt_max = max_q;

endmodule

// File: tb/tb_cov_stall_monitor.sv
// Directed bench for cov_stall_monitor; expectations are queued as stimulus is applied and checked on output.
module tb_cov_stall_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] cov;
  logic [1:0]  ch_mask;
  logic        done;
  logic        irq_ack;
  logic        irq;
  logic [2:0]  irq_cause;
  logic [15:0] stall_cnt_max;

  logic        tog1 = 1'b0;
  int          total = 0;
  int          passed = 0;
  int          lat;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  cov_stall_monitor #(
    .NUM_CH      (2),
    .COV_W       (8),
    .CNT_W       (16),
    .BASE_WAIT   (10),
    .SCALE_SHIFT (4),
    .WDOG_W      (32),
    .WDOG_LIMIT  (100),
    .HOLDOFF     (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .cov           (cov),
    .ch_mask       (ch_mask),
    .done          (done),
    .irq_ack       (irq_ack),
    .irq           (irq),
    .irq_cause     (irq_cause),
    .stall_cnt_max (stall_cnt_max)
  );

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (tog1) cov[15:8] = cov[15:8] ^ 8'hFF;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_irq(output int n, input int bound);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if (irq === 1'b1) break;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) passed++;
    else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b1;
    cov     = 16'hA3C5;
    ch_mask = 2'b11;
    done    = 1'b0;
    irq_ack = 1'b0;

    // Reset hold
    steps(3);
    push("rst_irq", 0); push("rst_cause", 0); push("rst_max", 0);
    pop_check(32'(irq)); pop_check(32'(irq_cause)); pop_check(32'(stall_cnt_max));
    reset = 1'b1;
    push("post_rst_irq", 0); push("post_rst_cause", 0); push("post_rst_max", 0);
    step();
    pop_check(32'(irq)); pop_check(32'(irq_cause)); pop_check(32'(stall_cnt_max));

    // Scaled stall: ch0=0x25 -> thr 30, ch1 toggling
    cov[7:0] = 8'h25;
    tog1 = 1'b1;
    done = 1'b1;
    push("scaled_latency", 31); push("scaled_cause", 3'b001);
    step();
    done = 1'b0;
    wait_irq(lat, 60);
    pop_check(32'(lat)); pop_check(32'(irq_cause));

    // Mask and watchdog
    tog1 = 1'b0;
    cov = 16'h3377;
    ch_mask = 2'b00;
    done = 1'b1;
    push("wdog_latency", 101); push("wdog_cause", 3'b100); push("wdog_max", 100);
    step();
    done = 1'b0;
    wait_irq(lat, 150);
    pop_check(32'(lat)); pop_check(32'(irq_cause)); pop_check(32'(stall_cnt_max));

    // Ack and hold-off: ch0=0x05 -> thr 10, refire 11 edges after ack
    cov = 16'h0505;
    ch_mask = 2'b01;
    irq_ack = 1'b1;
    push("ack_irq_low", 0); push("refire_latency", 11); push("refire_cause", 3'b001);
    push("fired_hold_irq", 1); push("fired_hold_cause", 3'b001);
    step();
    irq_ack = 1'b0;
    pop_check(32'(irq));
    wait_irq(lat, 50);
    pop_check(32'(lat)); pop_check(32'(irq_cause));
    steps(3);
    pop_check(32'(irq)); pop_check(32'(irq_cause));

    // done together with ack and a ch1 threshold hit
    ch_mask = 2'b11;
    done = 1'b1;
    irq_ack = 1'b1;
    push("simul_irq", 0); push("simul_cause", 0); push("simul_max", 0); push("simul_irq_after", 0);
    step();
    done = 1'b0;
    irq_ack = 1'b0;
    pop_check(32'(irq)); pop_check(32'(irq_cause));
    step();
    pop_check(32'(stall_cnt_max)); pop_check(32'(irq));

    // Freeze at cnt0=7, then resume: cnt hits 10 on 3rd edge, irq on 4th
    ch_mask = 2'b01;
    steps(6);
    en = 1'b0;
    push("freeze_irq", 0); push("freeze_max", 7); push("resume_latency", 4); push("resume_cause", 3'b001);
    steps(50);
    pop_check(32'(irq)); pop_check(32'(stall_cnt_max));
    en = 1'b1;
    wait_irq(lat, 20);
    pop_check(32'(lat)); pop_check(32'(irq_cause));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
